fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the MIPS single-cycle datapath. Holds the PC, fetches one 32-bit instruction per step over a ready-handshaked instruction-memory port, and presents it, with its opcode field, to the general control unit and the decode/execute logic. When the rest of the datapath retires the instruction, the block computes the next PC (sequential, BEQ/BNE branch, or J) from the control unit's `Branch`/`Jump` outputs and the ALU `Zero` flag, then fetches again.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; bits [1:0] forced to 0.

Ports:
- `Clk`, input, 1: single clock; all state updates on the rising edge.
- `Reset`, input, 1: synchronous, active-high.
- `ImemReq`, output, 1: fetch request to instruction memory.
- `ImemAddr`, output, 32: byte address of the fetch; equals `PC`.
- `ImemReady`, input, 1: memory has `ImemRdata` valid this cycle.
- `ImemRdata`, input, 32: fetched instruction word.
- `Instruction`, output, 32: latched instruction.
- `Opcode`, output, 6: `Instruction[31:26]`; drives the control unit.
- `InstrValid`, output, 1: `Instruction` is valid and awaiting retirement.
- `PC`, output, 32: address of the current instruction.
- `PCPlus4`, output, 32: `PC + 4`, modulo 2^32.
- `Advance`, input, 1: the datapath retires the current instruction. `Branch`, `Jump`, and `Zero` are valid in this cycle.
- `Branch`, input, 1: from the control unit.
- `Jump`, input, 1: from the control unit.
- `Zero`, input, 1: ALU zero flag.

## Operation
- The FSM has three states: IDLE, REQ, VALID.
- IDLE is the reset state. It always moves to REQ on the next cycle.
- REQ:
  - `ImemReq`=1 and `ImemAddr`=`PC`.
  - On `ImemReady`=1: latch `ImemRdata` into `Instruction` and go to VALID.
  - Otherwise stay in REQ with the request and address held stable.
- VALID:
  - `InstrValid`=1. `ImemReq`=0.
  - On `Advance`=1: load the next PC, clear `InstrValid`, and go to REQ.
  - Otherwise hold everything.
- Next-PC selection, evaluated in the `Advance` cycle, first match wins:
  - `Jump`=1: {`PCPlus4[31:28]`, `Instruction[25:0]`, 2'b00}.
  - `Branch`=1 and taken: `PCPlus4` + (sign-extended `Instruction[15:0]` << 2), 32-bit wrap.
    - Taken means `Zero`=1 when `Opcode`=BEQ (000100).
    - Taken means `Zero`=0 when `Opcode`=BNE (000101).
    - Any other opcode with `Branch`=1 is not taken.
  - Otherwise: `PCPlus4`.
- Ignored inputs:
  - `Advance` outside VALID.
  - `ImemReady` outside REQ.
  - `Branch`, `Jump`, and `Zero` outside `Advance` cycles.
- Wrap-around: `PC`=32'hFFFF_FFFC sequentially advances to 32'h0000_0000.
- `Instruction` holds its last value while in REQ. Consumers must qualify it with `InstrValid`.

## Timing
- Reset values, visible after the first rising edge with `Reset`=1:
  - state IDLE, `PC`=`RESET_PC`, `Instruction`=0, `InstrValid`=0, `ImemReq`=0.
  - Derived outputs follow: `Opcode`=0, `ImemAddr`=`RESET_PC`, `PCPlus4`=`RESET_PC`+4.
- Reset mid-fetch or mid-VALID: an outstanding request is abandoned and the fetched word is discarded. The memory must tolerate `ImemReq` dropping without a ready.
- `ImemReq`, `InstrValid`, and `ImemAddr` are decoded from registered state and registered `PC`, with no combinational path from inputs. This keeps memories with ready in the same cycle as request loop-free.
- Latency:
  - First request is asserted in the 2nd cycle after `Reset` deasserts.
  - With `ImemReady` returned in the same cycle as the request, `InstrValid` rises 1 cycle after the request.
  - Best-case throughput is 1 instruction per 2 cycles (REQ, VALID), plus memory wait cycles.
- `Advance` and `ImemReady` in the same cycle cannot conflict, because they are only acted on in different states.
- The new `PC` is visible the cycle after `Advance`, with `ImemReq` asserted in that same cycle.

## Structure
- Shared package `mips_pkg` holds:
  - opcode constants `OP_RTYPE`, `OP_BEQ`, `OP_BNE`, `OP_J`, matching the control unit's encodings;
  - the fetch state type (IDLE/REQ/VALID);
  - default reset-PC constant.
- Sub-module `next_pc_sel`: purely combinational. Inputs are `PCPlus4`, `Instruction`, `Branch`, `Jump`, `Zero`; output is the next PC. Reused by a later pipelined variant.
- Top level: FSM, PC register, instruction register, output decode.

## Test plan
- Reset then instant memory (`ImemReady` tied 1), reading 32'h2008_0005 at address 0:
  - `ImemReq` high in cycle 2;
  - `InstrValid`=1 in cycle 3 with `Opcode`=001000;
  - after `Advance` with `Branch`=`Jump`=0, `PC`=4.
- Wait states: hold `ImemReady`=0 for 3 cycles → `ImemReq` and `ImemAddr` remain stable, `InstrValid` stays 0, and the instruction is latched on the ready cycle.
- BEQ at `PC`=0x40, imm=0xFFFE:
  - `Zero`=1 → `PC`=0x3C;
  - `Zero`=0 → `PC`=0x44.
- BNE at `PC`=0x40, imm=0x0003:
  - `Zero`=0 → `PC`=0x50;
  - `Zero`=1 → `PC`=0x44.
- J at `PC`=0x1000_0010 with target field 0x000_0100 → `PC`=0x1000_0400. `Jump`=1 together with `Branch`=1 still jumps.
- Boundary and reset cases:
  - `PC`=0xFFFF_FFFC sequential → 0x0;
  - `Reset` asserted in REQ with a pending request → `ImemReq`=0 and `PC`=`RESET_PC` after the edge;
  - `Advance` pulsed in REQ → ignored.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Brief    : Shared opcodes, fetch state type and reset-PC default.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_REQ   = 2'd1,
        FETCH_VALID = 2'd2
    } fetch_state_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/next_pc_sel.sv
`default_nettype none
// ============================================================================
// Module   : next_pc_sel
// Brief    : Combinational next-PC select: jump, taken BEQ/BNE, or PC+4.
// Revision : 1.0 - initial release
// ============================================================================
module next_pc_sel
    import mips_pkg::*;
(
    input  logic [31:0] i_pc_plus4,
    input  logic [31:0] i_instruction,
    input  logic        i_branch,
    input  logic        i_jump,
    input  logic        i_zero,
    output logic [31:0] o_next_pc
);

    logic [5:0]  w_opcode;
    logic [31:0] w_branch_offset;
    logic [31:0] w_branch_target;
    logic [31:0] w_jump_target;
    logic        w_taken;

    assign w_opcode        = i_instruction[31:26];
    assign w_branch_offset = {{14{i_instruction[15]}}, i_instruction[15:0], 2'b00};
    assign w_branch_target = i_pc_plus4 + w_branch_offset;
    assign w_jump_target   = {i_pc_plus4[31:28], i_instruction[25:0], 2'b00};

    // Branch with an opcode other than BEQ/BNE is treated as not taken.
    always_comb begin
        w_taken = 1'b0;
        if (i_branch) begin
            if (w_opcode == OP_BEQ) begin
                w_taken = i_zero;
            end else if (w_opcode == OP_BNE) begin
                w_taken = ~i_zero;
            end
        end
    end

    always_comb begin
        o_next_pc = i_pc_plus4;
        if (i_jump) begin
            o_next_pc = w_jump_target;
        end else if (w_taken) begin
            o_next_pc = w_branch_target;
        end
    end

endmodule : next_pc_sel
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction fetch stage: PC register, ready-handshaked fetch,
//            instruction latch and next-PC update on retirement.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemReady,
    input  logic [31:0] ImemRdata,
    output logic [31:0] Instruction,
    output logic [5:0]  Opcode,
    output logic        InstrValid,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    input  logic        Advance,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        Zero
);

    localparam logic [31:0] C_RESET_PC = {RESET_PC[31:2], 2'b00};

    fetch_state_t r_state_q;
    fetch_state_t w_state_d;
    logic [31:0]  r_pc_q;
    logic [31:0]  w_pc_d;
    logic [31:0]  r_instr_q;
    logic [31:0]  w_instr_d;
    logic [31:0]  w_pc_plus4;
    logic [31:0]  w_next_pc;

    assign w_pc_plus4 = r_pc_q + 32'd4;

    next_pc_sel u_next_pc_sel (
        .i_pc_plus4    (w_pc_plus4),
        .i_instruction (r_instr_q),
        .i_branch      (Branch),
        .i_jump        (Jump),
        .i_zero        (Zero),
        .o_next_pc     (w_next_pc)
    );

    always_comb begin
        w_state_d = r_state_q;
        w_pc_d    = r_pc_q;
        w_instr_d = r_instr_q;
        case (r_state_q)
            FETCH_IDLE: begin
                w_state_d = FETCH_REQ;
            end
            FETCH_REQ: begin
                if (ImemReady) begin
                    w_instr_d = ImemRdata;
                    w_state_d = FETCH_VALID;
                end
            end
            FETCH_VALID: begin
                if (Advance) begin
                    w_pc_d    = w_next_pc;
                    w_state_d = FETCH_REQ;
                end
            end
            default: begin
                w_state_d = FETCH_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state_q <= FETCH_IDLE;
            r_pc_q    <= C_RESET_PC;
            r_instr_q <= 32'h0000_0000;
        end else begin
            r_state_q <= w_state_d;
            r_pc_q    <= w_pc_d;
            r_instr_q <= w_instr_d;
        end
    end

    // Handshake outputs come only from registered state so a memory that
    // answers in the request cycle cannot form a combinational loop.
    assign ImemReq     = (r_state_q == FETCH_REQ);
    assign InstrValid  = (r_state_q == FETCH_VALID);
    assign ImemAddr    = r_pc_q;
    assign PC          = r_pc_q;
    assign PCPlus4     = w_pc_plus4;
    assign Instruction = r_instr_q;
    assign Opcode      = r_instr_q[31:26];

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed self-checking bench for fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        Clk;
    logic        Reset;
    logic        ImemReady;
    logic [31:0] ImemRdata;
    logic        Advance;
    logic        Branch;
    logic        Jump;
    logic        Zero;

    logic        ImemReq,    hi_ImemReq;
    logic [31:0] ImemAddr,   hi_ImemAddr;
    logic [31:0] Instruction, hi_Instruction;
    logic [5:0]  Opcode,     hi_Opcode;
    logic        InstrValid, hi_InstrValid;
    logic [31:0] PC,         hi_PC;
    logic [31:0] PCPlus4,    hi_PCPlus4;

    int pass_cnt  = 0;
    int total_cnt = 0;

    fetch_unit u_dut (
        .Clk(Clk), .Reset(Reset), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
        .ImemReady(ImemReady), .ImemRdata(ImemRdata), .Instruction(Instruction),
        .Opcode(Opcode), .InstrValid(InstrValid), .PC(PC), .PCPlus4(PCPlus4),
        .Advance(Advance), .Branch(Branch), .Jump(Jump), .Zero(Zero)
    );

    // Second instance in the 0x1xxx_xxxx region for the jump test; the low
    // address bits of its reset PC must be dropped.
    fetch_unit #(.RESET_PC(32'h1000_0013)) u_dut_hi (
        .Clk(Clk), .Reset(Reset), .ImemReq(hi_ImemReq), .ImemAddr(hi_ImemAddr),
        .ImemReady(ImemReady), .ImemRdata(ImemRdata), .Instruction(hi_Instruction),
        .Opcode(hi_Opcode), .InstrValid(hi_InstrValid), .PC(hi_PC), .PCPlus4(hi_PCPlus4),
        .Advance(Advance), .Branch(Branch), .Jump(Jump), .Zero(Zero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic go_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] word);
        ImemRdata = word;
        ImemReady = 1'b1;
        tick();
        ImemReady = 1'b0;
    endtask

    task automatic retire(input logic b, input logic j, input logic z);
        Advance = 1'b1; Branch = b; Jump = j; Zero = z;
        tick();
        Advance = 1'b0; Branch = 1'b0; Jump = 1'b0; Zero = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        tick();
        total_cnt++; if (PC !== 32'h0) $display("FAIL reset_pc: got %h want %h", PC, 32'h0); else pass_cnt++;
        total_cnt++; if (ImemReq !== 1'b0) $display("FAIL reset_req: got %b want 0", ImemReq); else pass_cnt++;
        total_cnt++; if (InstrValid !== 1'b0) $display("FAIL reset_valid: got %b want 0", InstrValid); else pass_cnt++;
        total_cnt++; if (Instruction !== 32'h0) $display("FAIL reset_instr: got %h want 0", Instruction); else pass_cnt++;
        total_cnt++; if (Opcode !== 6'h0) $display("FAIL reset_opcode: got %h want 0", Opcode); else pass_cnt++;
        total_cnt++; if (PCPlus4 !== 32'h4) $display("FAIL reset_pcplus4: got %h want 4", PCPlus4); else pass_cnt++;
        total_cnt++; if (hi_PC !== 32'h1000_0010) $display("FAIL reset_hi_pc: got %h want 10000010", hi_PC); else pass_cnt++;
        total_cnt++; if (hi_ImemAddr !== 32'h1000_0010) $display("FAIL reset_hi_addr: got %h want 10000010", hi_ImemAddr); else pass_cnt++;
    endtask

    task automatic test_first_fetch();
        ImemReady = 1'b1;
        ImemRdata = 32'h2008_0005;
        Reset = 1'b0;
        total_cnt++; if (ImemReq !== 1'b0) $display("FAIL first_cyc1_req: got %b want 0", ImemReq); else pass_cnt++;
        tick();
        total_cnt++; if (ImemReq !== 1'b1) $display("FAIL first_cyc2_req: got %b want 1", ImemReq); else pass_cnt++;
        total_cnt++; if (ImemAddr !== 32'h0) $display("FAIL first_cyc2_addr: got %h want 0", ImemAddr); else pass_cnt++;
        total_cnt++; if (InstrValid !== 1'b0) $display("FAIL first_cyc2_valid: got %b want 0", InstrValid); else pass_cnt++;
        tick();
        total_cnt++; if (InstrValid !== 1'b1) $display("FAIL first_cyc3_valid: got %b want 1", InstrValid); else pass_cnt++;
        total_cnt++; if (ImemReq !== 1'b0) $display("FAIL first_cyc3_req: got %b want 0", ImemReq); else pass_cnt++;
        total_cnt++; if (Opcode !== 6'b001000) $display("FAIL first_opcode: got %b want 001000", Opcode); else pass_cnt++;
        total_cnt++; if (Instruction !== 32'h2008_0005) $display("FAIL first_instr: got %h want 20080005", Instruction); else pass_cnt++;
        ImemReady = 1'b0;
        retire(1'b0, 1'b0, 1'b0);
        total_cnt++; if (PC !== 32'h4) $display("FAIL first_next_pc: got %h want 4", PC); else pass_cnt++;
        total_cnt++; if (ImemReq !== 1'b1) $display("FAIL first_next_req: got %b want 1", ImemReq); else pass_cnt++;
        total_cnt++; if (InstrValid !== 1'b0) $display("FAIL first_next_valid: got %b want 0", InstrValid); else pass_cnt++;
    endtask

    task automatic test_wait_states();
        ImemReady = 1'b0;
        ImemRdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++; if (ImemReq !== 1'b1) $display("FAIL wait%0d_req: got %b want 1", i, ImemReq); else pass_cnt++;
            total_cnt++; if (ImemAddr !== 32'h4) $display("FAIL wait%0d_addr: got %h want 4", i, ImemAddr); else pass_cnt++;
            total_cnt++; if (InstrValid !== 1'b0) $display("FAIL wait%0d_valid: got %b want 0", i, InstrValid); else pass_cnt++;
            total_cnt++; if (Instruction !== 32'h2008_0005) $display("FAIL wait%0d_hold: got %h want 20080005", i, Instruction); else pass_cnt++;
        end
        fetch(32'h0000_0020);
        total_cnt++; if (InstrValid !== 1'b1) $display("FAIL wait_ready_valid: got %b want 1", InstrValid); else pass_cnt++;
        total_cnt++; if (Instruction !== 32'h0000_0020) $display("FAIL wait_ready_instr: got %h want 00000020", Instruction); else pass_cnt++;
        retire(1'b0, 1'b0, 1'b0);
        total_cnt++; if (PC !== 32'h8) $display("FAIL wait_next_pc: got %h want 8", PC); else pass_cnt++;
    endtask

    task automatic test_ignored_inputs();
        ImemReady = 1'b0;
        Advance = 1'b1; Branch = 1'b1; Jump = 1'b1; Zero = 1'b1;
        tick();
        tick();
        Advance = 1'b0; Branch = 1'b0; Jump = 1'b0; Zero = 1'b0;
        total_cnt++; if (PC !== 32'h8) $display("FAIL adv_in_req_pc: got %h want 8", PC); else pass_cnt++;
        total_cnt++; if (ImemReq !== 1'b1) $display("FAIL adv_in_req_req: got %b want 1", ImemReq); else pass_cnt++;
        total_cnt++; if (InstrValid !== 1'b0) $display("FAIL adv_in_req_valid: got %b want 0", InstrValid); else pass_cnt++;
        fetch(32'h0800_0010);
        ImemReady = 1'b1;
        ImemRdata = 32'hFFFF_FFFF;
        tick();
        ImemReady = 1'b0;
        total_cnt++; if (Instruction !== 32'h0800_0010) $display("FAIL ready_in_valid_instr: got %h want 08000010", Instruction); else pass_cnt++;
        total_cnt++; if (InstrValid !== 1'b1) $display("FAIL ready_in_valid_valid: got %b want 1", InstrValid); else pass_cnt++;
        retire(1'b0, 1'b1, 1'b0);
        total_cnt++; if (PC !== 32'h40) $display("FAIL jump_to_40: got %h want 40", PC); else pass_cnt++;
    endtask

    task automatic test_beq();
        fetch(32'h1000_FFFE);
        retire(1'b1, 1'b0, 1'b1);
        total_cnt++; if (PC !== 32'h3C) $display("FAIL beq_taken: got %h want 3c", PC); else pass_cnt++;
        fetch(32'h0800_0010);
        retire(1'b0, 1'b1, 1'b0);
        total_cnt++; if (PC !== 32'h40) $display("FAIL beq_jump_back: got %h want 40", PC); else pass_cnt++;
        fetch(32'h1000_FFFE);
        retire(1'b1, 1'b0, 1'b0);
        total_cnt++; if (PC !== 32'h44) $display("FAIL beq_not_taken: got %h want 44", PC); else pass_cnt++;
    endtask

    task automatic test_bne();
        fetch(32'h0800_0010);
        retire(1'b0, 1'b1, 1'b0);
        fetch(32'h1400_0003);
        retire(1'b1, 1'b0, 1'b0);
        total_cnt++; if (PC !== 32'h50) $display("FAIL bne_taken: got %h want 50", PC); else pass_cnt++;
        fetch(32'h0800_0010);
        retire(1'b0, 1'b1, 1'b0);
        fetch(32'h1400_0003);
        retire(1'b1, 1'b0, 1'b1);
        total_cnt++; if (PC !== 32'h44) $display("FAIL bne_not_taken: got %h want 44", PC); else pass_cnt++;
        fetch(32'h2008_FFFE);
        retire(1'b1, 1'b0, 1'b1);
        total_cnt++; if (PC !== 32'h48) $display("FAIL branch_other_op: got %h want 48", PC); else pass_cnt++;
    endtask

    task automatic test_wrap();
        fetch(32'h0800_0000);
        retire(1'b0, 1'b1, 1'b0);
        total_cnt++; if (PC !== 32'h0) $display("FAIL wrap_jump_zero: got %h want 0", PC); else pass_cnt++;
        fetch(32'h1000_FFFE);
        retire(1'b1, 1'b0, 1'b1);
        total_cnt++; if (PC !== 32'hFFFF_FFFC) $display("FAIL wrap_top_pc: got %h want fffffffc", PC); else pass_cnt++;
        total_cnt++; if (PCPlus4 !== 32'h0) $display("FAIL wrap_pcplus4: got %h want 0", PCPlus4); else pass_cnt++;
        fetch(32'h0000_0000);
        retire(1'b0, 1'b0, 1'b0);
        total_cnt++; if (PC !== 32'h0) $display("FAIL wrap_seq: got %h want 0", PC); else pass_cnt++;
        total_cnt++; if (ImemAddr !== 32'h0) $display("FAIL wrap_addr: got %h want 0", ImemAddr); else pass_cnt++;
    endtask

    task automatic test_jump_hi();
        go_reset();
        tick();
        fetch(32'h0800_0100);
        total_cnt++; if (hi_Opcode !== 6'b000010) $display("FAIL hi_opcode: got %b want 000010", hi_Opcode); else pass_cnt++;
        retire(1'b1, 1'b1, 1'b1);
        total_cnt++; if (hi_PC !== 32'h1000_0400) $display("FAIL hi_jump_pc: got %h want 10000400", hi_PC); else pass_cnt++;
        total_cnt++; if (hi_ImemReq !== 1'b1) $display("FAIL hi_jump_req: got %b want 1", hi_ImemReq); else pass_cnt++;
        total_cnt++; if (PC !== 32'h0000_0400) $display("FAIL lo_jump_pc: got %h want 400", PC); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        ImemReady = 1'b0;
        Reset = 1'b1;
        tick();
        total_cnt++; if (ImemReq !== 1'b0) $display("FAIL rst_req_req: got %b want 0", ImemReq); else pass_cnt++;
        total_cnt++; if (PC !== 32'h0) $display("FAIL rst_req_pc: got %h want 0", PC); else pass_cnt++;
        total_cnt++; if (hi_PC !== 32'h1000_0010) $display("FAIL rst_req_hi_pc: got %h want 10000010", hi_PC); else pass_cnt++;
        Reset = 1'b0;
        tick();
        fetch(32'h1234_5678);
        total_cnt++; if (InstrValid !== 1'b1) $display("FAIL rst_valid_pre: got %b want 1", InstrValid); else pass_cnt++;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        total_cnt++; if (InstrValid !== 1'b0) $display("FAIL rst_valid_valid: got %b want 0", InstrValid); else pass_cnt++;
        total_cnt++; if (Instruction !== 32'h0) $display("FAIL rst_valid_instr: got %h want 0", Instruction); else pass_cnt++;
    endtask

    initial begin
        Reset = 1'b1; ImemReady = 1'b0; ImemRdata = 32'h0;
        Advance = 1'b0; Branch = 1'b0; Jump = 1'b0; Zero = 1'b0;
        test_reset();
        test_first_fetch();
        test_wait_states();
        test_ignored_inputs();
        test_beq();
        test_bne();
        test_wrap();
        test_jump_hi();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire
